lpe_column_drain: RTL and testbench

Receive-side terminus of a LinearProcessingElement column. It sits below the bottom PE and consumes that PE's down stream. Each column pass delivers PE_NUMBER_J result words tagged with the RSLT user flag, topmost row first. The block discards operand spill-over words, checks result ordering and flags, and re-emits each group of PE_NUMBER_J results as one AXI-Stream packet with fixed tid/tdest.

---
 rtl/lpe_column_drain.sv | 154 +++++++++++++++
 tb/tb_lpe_column_drain.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lpe_column_drain.sv
// Column drain: filters operand spill-over and checks result order/flags, then repacks each
// group of PE_NUMBER_J results as one AXI-Stream packet. Optional row tag on m_axis_tuser: LPE_DRAIN_ROW_TAG_EN.
//
// state   | meaning
// IDLE    | waiting for the first result word of a group (count == 0)
// COLLECT | part of a group has been forwarded; count = index of the next word
// FLUSH   | after an error, drop every word up to and including the next s_tlast
module lpe_column_drain #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    PE_NUMBER_J    = 4,
    parameter int                    USER_WIDTH     = 8,
    parameter logic [USER_WIDTH-1:0] OP1_USER_MASK  = USER_WIDTH'(1) << (USER_WIDTH-2),
    parameter logic [USER_WIDTH-1:0] RSLT_USER_MASK = USER_WIDTH'(1) << (USER_WIDTH-1),
    parameter int                    ID_WIDTH       = 8,
    parameter int                    DEST_WIDTH     = 8,
    parameter int                    OUTPUT_ID      = 1,
    parameter int                    OUTPUT_DEST    = 1,
    localparam int                   IDX_W          = (PE_NUMBER_J > 1) ? $clog2(PE_NUMBER_J) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
`ifdef LPE_DRAIN_ROW_TAG_EN
    output logic [IDX_W-1:0]      m_axis_tuser,
`endif
    output logic                  busy,
    output logic                  err_order,
    output logic                  err_user_flag
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PE_NUMBER_J - 1);

`ifdef LPE_DRAIN_ROW_TAG_EN
    localparam int PW = DATA_WIDTH + 1 + IDX_W;
`else
    localparam int PW = DATA_WIDTH + 1;
`endif

    state_t           state;
    logic [IDX_W-1:0] count;
    logic             rdy_q;
    logic [1:0]       occ;
    logic [PW-1:0]    head, spare, in_pl;

    logic s_hs, has_rslt, has_op, w_rslt, w_bad, at_last, in_flush, order_bad, push, pop;

    assign s_axis_tready = rdy_q && (occ != 2'd2);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign has_rslt      = |(s_axis_tuser & RSLT_USER_MASK);
    assign has_op        = |(s_axis_tuser & OP1_USER_MASK);
    assign w_rslt        = has_rslt && !has_op;
    assign w_bad         = (has_rslt == has_op);
    assign at_last       = (count == LAST_IDX);
    assign in_flush      = (state == S_FLUSH);
    assign order_bad     = w_rslt && (s_axis_tlast != at_last);
    assign push          = s_hs && !in_flush && w_rslt && !order_bad;
    assign pop           = (occ != 2'd0) && m_axis_tready;

`ifdef LPE_DRAIN_ROW_TAG_EN
    assign in_pl        = {count, at_last, s_axis_tdata};
    assign m_axis_tuser = head[PW-1 -: IDX_W];
`else
    assign in_pl        = {at_last, s_axis_tdata};
`endif

    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = head[DATA_WIDTH];
    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tid    = ID_WIDTH'(OUTPUT_ID);
    assign m_axis_tdest  = DEST_WIDTH'(OUTPUT_DEST);
    assign busy          = (count != '0) || in_flush;

    // Two-entry skid: head drives the output, spare catches the word that arrives during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            occ   <= 2'd0;
            head  <= '0;
            spare <= '0;
        end else begin
            rdy_q <= 1'b1;
            case (occ)
                2'd0: if (push) begin
                    head <= in_pl;
                    occ  <= 2'd1;
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_pl;
                    end else if (push) begin
                        spare <= in_pl;
                        occ   <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                2'd2: if (pop) begin
                    head <= spare;
                    occ  <= 2'd1;
                end
                default: occ <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            count         <= '0;
            err_order     <= 1'b0;
            err_user_flag <= 1'b0;
        end else begin
            err_order     <= 1'b0;
            err_user_flag <= 1'b0;
            if (s_hs) begin
                if (in_flush) begin
                    if (s_axis_tlast) begin
                        state <= S_IDLE;
                        count <= '0;
                    end
                end else if (w_bad) begin
                    err_user_flag <= 1'b1;
                    state         <= S_FLUSH;
                    count         <= '0;
                end else if (w_rslt) begin
                    if (order_bad) begin
                        err_order <= 1'b1;
                        count     <= '0;
                        state     <= s_axis_tlast ? S_IDLE : S_FLUSH;
                    end else if (at_last) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else begin
                        count <= count + IDX_W'(1);
                        state <= S_COLLECT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lpe_column_drain.sv
// Directed bench for lpe_column_drain with PE_NUMBER_J=4; row tags are checked when LPE_DRAIN_ROW_TAG_EN is set.
module tb_lpe_column_drain;

    localparam logic [7:0] RSLT = 8'h80;
    localparam logic [7:0] OP1  = 8'h40;
    localparam logic [7:0] BOTH = 8'hC0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  s_axis_tuser = '0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tid;
    logic [7:0]  m_axis_tdest;
    logic [1:0]  m_axis_tuser;
    logic        busy, err_order, err_user_flag;

    lpe_column_drain dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
`ifdef LPE_DRAIN_ROW_TAG_EN
        .m_axis_tuser(m_axis_tuser),
`endif
        .busy(busy), .err_order(err_order), .err_user_flag(err_user_flag)
    );

`ifndef LPE_DRAIN_ROW_TAG_EN
    assign m_axis_tuser = 2'd0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] oq_data[$];
    bit          oq_last[$];
    logic [1:0]  oq_user[$];
    int          oq_cyc[$];
    int          iq_cyc[$];
    int          eo_cnt = 0;
    int          eu_cnt = 0;

    // Observe handshakes between edges: whatever is valid&ready here completes at the next posedge.
    always begin
        @(negedge clk);
        #2;
        if (s_axis_tvalid && s_axis_tready) iq_cyc.push_back(cyc);
        if (m_axis_tvalid && m_axis_tready) begin
            oq_data.push_back(m_axis_tdata);
            oq_last.push_back(m_axis_tlast);
            oq_user.push_back(m_axis_tuser);
            oq_cyc.push_back(cyc);
        end
        if (err_order) eo_cnt++;
        if (err_user_flag) eu_cnt++;
    end

    task automatic clear_mon();
        oq_data.delete(); oq_last.delete(); oq_user.delete(); oq_cyc.delete(); iq_cyc.delete();
        eo_cnt = 0; eu_cnt = 0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [15:0] d, input logic [7:0] u, input logic l);
        int t = 0;
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        while (!s_axis_tready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            errors++;
            $display("FAIL send_timeout: s_axis_tready stayed %0b, required 1", s_axis_tready);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %0b need 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %0b need 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== 16'h0) begin errors++; $display("FAIL rst_tdata: got %h need 0", m_axis_tdata); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %0b need 0", s_axis_tready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b need 0", busy); end
        checks++; if ({err_order, err_user_flag} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b need 00", {err_order, err_user_flag}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rdy_after_rst: got %0b need 1", s_axis_tready); end
        checks++; if (m_axis_tid !== 8'd1 || m_axis_tdest !== 8'd1) begin errors++; $display("FAIL tid_tdest: got %0d/%0d need 1/1", m_axis_tid, m_axis_tdest); end
    endtask

    task automatic test_basic();
        logic [15:0] ed[4] = '{16'h11, 16'h22, 16'h33, 16'h44};
        clear_mon();
        for (int i = 0; i < 4; i++) send(ed[i], RSLT, i == 3);
        repeat (3) @(negedge clk);
        checks++; if (oq_data.size() != 4 || iq_cyc.size() != 4) begin errors++; $display("FAIL basic_count: got %0d out %0d in, need 4/4", oq_data.size(), iq_cyc.size()); end
        for (int i = 0; i < 4 && i < oq_data.size() && i < iq_cyc.size(); i++) begin
            checks++; if (oq_data[i] !== ed[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h need %h", i, oq_data[i], ed[i]); end
            checks++; if (oq_last[i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %0b need %0b", i, oq_last[i], i == 3); end
            checks++; if (oq_cyc[i] != iq_cyc[i] + 1) begin errors++; $display("FAIL basic_latency[%0d]: got %0d need %0d", i, oq_cyc[i] - iq_cyc[i], 1); end
`ifdef LPE_DRAIN_ROW_TAG_EN
            checks++; if (oq_user[i] !== 2'(i)) begin errors++; $display("FAIL basic_tag[%0d]: got %0d need %0d", i, oq_user[i], i); end
`endif
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %0b need 0", busy); end
    endtask

    task automatic test_op_interleave();
        logic [15:0] ed[4] = '{16'h11, 16'h22, 16'h33, 16'h44};
        clear_mon();
        send(16'h11, RSLT, 1'b0);
        send(16'h22, RSLT, 1'b0);
        send(16'hAA, OP1, 1'b0);
        send(16'hBB, OP1, 1'b0);
        send(16'h33, RSLT, 1'b0);
        send(16'h44, RSLT, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (oq_data.size() != 4) begin errors++; $display("FAIL op_count: got %0d need 4", oq_data.size()); end
        for (int i = 0; i < 4 && i < oq_data.size(); i++) begin
            checks++; if (oq_data[i] !== ed[i] || oq_last[i] !== (i == 3)) begin errors++; $display("FAIL op_word[%0d]: got %h/%0b need %h/%0b", i, oq_data[i], oq_last[i], ed[i], i == 3); end
`ifdef LPE_DRAIN_ROW_TAG_EN
            checks++; if (oq_user[i] !== 2'(i)) begin errors++; $display("FAIL op_tag[%0d]: got %0d need %0d", i, oq_user[i], i); end
`endif
        end
        checks++; if (eo_cnt != 0 || eu_cnt != 0) begin errors++; $display("FAIL op_errs: got %0d/%0d need 0/0", eo_cnt, eu_cnt); end
    endtask

    task automatic test_order_err();
        logic [15:0] ed[5] = '{16'h11, 16'hA1, 16'hA2, 16'hA3, 16'hA4};
        logic        el[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  eu[5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        clear_mon();
        send(16'h11, RSLT, 1'b0);
        send(16'h22, RSLT, 1'b1);
        checks++; if (err_order !== 1'b1) begin errors++; $display("FAIL order_pulse: got %0b need 1", err_order); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL order_busy: got %0b need 0", busy); end
        for (int i = 1; i < 5; i++) send(ed[i], RSLT, i == 4);
        repeat (3) @(negedge clk);
        checks++; if (eo_cnt != 1 || eu_cnt != 0) begin errors++; $display("FAIL order_errs: got %0d/%0d need 1/0", eo_cnt, eu_cnt); end
        checks++; if (oq_data.size() != 5) begin errors++; $display("FAIL order_count: got %0d need 5", oq_data.size()); end
        for (int i = 0; i < 5 && i < oq_data.size(); i++) begin
            checks++; if (oq_data[i] !== ed[i] || oq_last[i] !== el[i]) begin errors++; $display("FAIL order_word[%0d]: got %h/%0b need %h/%0b", i, oq_data[i], oq_last[i], ed[i], el[i]); end
`ifdef LPE_DRAIN_ROW_TAG_EN
            checks++; if (oq_user[i] !== eu[i]) begin errors++; $display("FAIL order_tag[%0d]: got %0d need %0d", i, oq_user[i], eu[i]); end
`endif
        end
    endtask

    task automatic test_bad_flag();
        logic [15:0] ed[6] = '{16'h11, 16'h22, 16'hB1, 16'hB2, 16'hB3, 16'hB4};
        logic        el[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  eu[6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
        clear_mon();
        send(16'h11, RSLT, 1'b0);
        send(16'h22, RSLT, 1'b0);
        send(16'h33, BOTH, 1'b0);
        checks++; if (err_user_flag !== 1'b1) begin errors++; $display("FAIL bad_pulse: got %0b need 1", err_user_flag); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bad_busy_flush: got %0b need 1", busy); end
        send(16'h44, RSLT, 1'b1);
        for (int i = 2; i < 6; i++) send(ed[i], RSLT, i == 5);
        repeat (3) @(negedge clk);
        checks++; if (eu_cnt != 1 || eo_cnt != 0) begin errors++; $display("FAIL bad_errs: got %0d/%0d need 1/0", eu_cnt, eo_cnt); end
        checks++; if (oq_data.size() != 6) begin errors++; $display("FAIL bad_count: got %0d need 6", oq_data.size()); end
        for (int i = 0; i < 6 && i < oq_data.size(); i++) begin
            checks++; if (oq_data[i] !== ed[i] || oq_last[i] !== el[i]) begin errors++; $display("FAIL bad_word[%0d]: got %h/%0b need %h/%0b", i, oq_data[i], oq_last[i], ed[i], el[i]); end
`ifdef LPE_DRAIN_ROW_TAG_EN
            checks++; if (oq_user[i] !== eu[i]) begin errors++; $display("FAIL bad_tag[%0d]: got %0d need %0d", i, oq_user[i], eu[i]); end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ed[4] = '{16'hC1, 16'hC2, 16'hC3, 16'hC4};
        clear_mon();
        m_axis_tready = 1'b0;
        send(ed[0], RSLT, 1'b0);
        send(ed[1], RSLT, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_tready[%0d]: got %0b need 0", i, s_axis_tready); end
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== ed[0]) begin errors++; $display("FAIL bp_hold[%0d]: got %0b/%h need 1/%h", i, m_axis_tvalid, m_axis_tdata, ed[0]); end
            @(negedge clk);
        end
        checks++; if (iq_cyc.size() != 2) begin errors++; $display("FAIL bp_accepted: got %0d need 2", iq_cyc.size()); end
        m_axis_tready = 1'b1;
        send(ed[2], RSLT, 1'b0);
        send(ed[3], RSLT, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (oq_data.size() != 4) begin errors++; $display("FAIL bp_count: got %0d need 4", oq_data.size()); end
        for (int i = 0; i < 4 && i < oq_data.size(); i++) begin
            checks++; if (oq_data[i] !== ed[i] || oq_last[i] !== (i == 3)) begin errors++; $display("FAIL bp_word[%0d]: got %h/%0b need %h/%0b", i, oq_data[i], oq_last[i], ed[i], i == 3); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] ed[4] = '{16'hE1, 16'hE2, 16'hE3, 16'hE4};
        m_axis_tready = 1'b1;
        send(16'hD1, RSLT, 1'b0);
        send(16'hD2, RSLT, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %0b need 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_clear: got tvalid %0b busy %0b need 0 0", m_axis_tvalid, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        for (int i = 0; i < 4; i++) send(ed[i], RSLT, i == 3);
        repeat (3) @(negedge clk);
        checks++; if (oq_data.size() != 4 || eo_cnt != 0) begin errors++; $display("FAIL mid_count: got %0d words %0d order errs need 4/0", oq_data.size(), eo_cnt); end
        for (int i = 0; i < 4 && i < oq_data.size(); i++) begin
            checks++; if (oq_data[i] !== ed[i] || oq_last[i] !== (i == 3)) begin errors++; $display("FAIL mid_word[%0d]: got %h/%0b need %h/%0b", i, oq_data[i], oq_last[i], ed[i], i == 3); end
`ifdef LPE_DRAIN_ROW_TAG_EN
            checks++; if (oq_user[i] !== 2'(i)) begin errors++; $display("FAIL mid_tag[%0d]: got %0d need %0d", i, oq_user[i], i); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_op_interleave();
        test_order_err();
        test_bad_flag();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
